// File: rtl/camera_frame_rx_pkg.sv
// cam_rx_pkg: shared state type and constants for the camera frame receiver
package cam_rx_pkg;
  typedef enum logic [1:0] {IDLE, SYNC, FRAME} state_t;
  localparam int CNT_W = 12;
  localparam int ERR_LEN = 0;
  localparam int ERR_CNT = 1;
  localparam int ERR_W = 2;
endpackage

// File: rtl/camera_frame_rx_if.sv
// camera_frame_rx_if: sensor timing inputs and flagged pixel stream of the camera receiver
interface camera_frame_rx_if
  import cam_rx_pkg::*;
#(
  parameter int DW = 10,
  parameter int CW = CNT_W
);
  logic fv;
  logic lv;
  logic pix_en;
  logic [DW-1:0] pix_data;
  logic px_valid;
  logic [DW-1:0] px_data;
  logic px_sof;
  logic px_eol;
  logic px_eof;
  logic [CW-1:0] x_pos;
  logic [CW-1:0] y_pos;
  modport master (
    output fv, lv, pix_en, pix_data,
    input  px_valid, px_data, px_sof, px_eol, px_eof, x_pos, y_pos
  );
  modport slave (
    input  fv, lv, pix_en, pix_data,
    output px_valid, px_data, px_sof, px_eol, px_eof, x_pos, y_pos
  );
endinterface

// File: rtl/camera_frame_rx_edge_detect.sv
// cam_edge_detect: registers a sensor timing strobe and flags its rising and falling edges
module cam_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic q_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {q, q_d} <= '0;
    else {q, q_d} <= {d, q};
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;
endmodule

// File: rtl/camera_frame_rx.sv
// camera_frame_rx: parallel camera receiver emitting a flagged pixel stream with frame geometry checks
module camera_frame_rx
  import cam_rx_pkg::*;
#(
  parameter int HPIX = 640,
  parameter int VPIX = 400,
  parameter int DW = 10,
  parameter int CW = CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic err_clr,
  camera_frame_rx_if.slave bus,
  output logic frame_done,
  output logic [15:0] frame_count,
  output logic [CW-1:0] last_line_len,
  output logic err_line_len,
  output logic err_line_cnt
);
  localparam logic [CW-1:0] H = CW'(HPIX);
  localparam logic [CW-1:0] V = CW'(VPIX);
  localparam logic [CW-1:0] HL = CW'(HPIX - 1);
  localparam logic [CW-1:0] VL = CW'(VPIX - 1);
  state_t state, state_nx;
  logic primed, pe_q;
  logic [DW-1:0] pd_q;
  logic fv_q, fv_rise, fv_fall, lv_q, lv_rise_unused, lv_fall;
  logic [CW-1:0] col, row, row_nx;
  logic [ERR_W-1:0] err;
  logic acc, emit, line_end, frame_end;
  cam_edge_detect u_fv (.clk(clk), .reset_n(reset_n), .d(bus.fv), .q(fv_q), .rise(fv_rise), .fall(fv_fall));
  cam_edge_detect u_lv (.clk(clk), .reset_n(reset_n), .d(bus.lv), .q(lv_q), .rise(lv_rise_unused), .fall(lv_fall));
  assign acc = state == FRAME && lv_q && pe_q;
  assign emit = acc && col < H && row < V;
  assign line_end = state == FRAME && lv_fall && col != '0;
  assign frame_end = state == FRAME && fv_fall;
  assign row_nx = line_end && row != '1 ? row + 1'b1 : row;
  assign err_line_len = err[ERR_LEN];
  assign err_line_cnt = err[ERR_CNT];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (primed && !fv_q ? SYNC : IDLE)
             : state == SYNC ? (fv_rise && enable ? FRAME : SYNC)
             : (frame_end ? SYNC : FRAME);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      primed <= 1'b0;
      pe_q <= 1'b0;
      pd_q <= '0;
      col <= '0;
      row <= '0;
      err <= '0;
      frame_done <= 1'b0;
      frame_count <= '0;
      last_line_len <= '0;
      bus.px_valid <= 1'b0;
      bus.px_data <= '0;
      bus.px_sof <= 1'b0;
      bus.px_eol <= 1'b0;
      bus.px_eof <= 1'b0;
      bus.x_pos <= '0;
      bus.y_pos <= '0;
    end else begin
      primed <= 1'b1;
      pe_q <= bus.pix_en;
      pd_q <= bus.pix_data;
      col <= state != FRAME || lv_fall ? '0 : (acc && col != '1 ? col + 1'b1 : col);
      row <= state != FRAME ? '0 : row_nx;
      bus.px_valid <= emit;
      bus.px_data <= pd_q;
      bus.px_sof <= emit && col == '0 && row == '0;
      bus.px_eol <= emit && col == HL;
      bus.px_eof <= emit && col == HL && row == VL;
      bus.x_pos <= col;
      bus.y_pos <= row;
      frame_done <= frame_end;
      frame_count <= frame_count + 16'(frame_end);
      if (line_end) last_line_len <= col;
      err[ERR_LEN] <= (line_end && col != H) || (err[ERR_LEN] && !err_clr);
      err[ERR_CNT] <= (frame_end && row_nx != V) || (err[ERR_CNT] && !err_clr);
    end
endmodule

// File: tb/tb_camera_frame_rx.sv
// tb_camera_frame_rx: randomized scoreboard bench for the camera frame receiver
module tb_camera_frame_rx;
  localparam int HPIX = 16;
  localparam int VPIX = 4;
  localparam int DW = 10;
  localparam int CW = 12;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic sof;
    logic eol;
    logic eof;
  } px_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic err_clr = 1'b0;
  logic frame_done, err_line_len, err_line_cnt;
  logic [15:0] frame_count;
  logic [CW-1:0] last_line_len;
  camera_frame_rx_if #(.DW(DW), .CW(CW)) bus ();
  camera_frame_rx #(.HPIX(HPIX), .VPIX(VPIX), .DW(DW), .CW(CW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .err_clr(err_clr),
    .bus(bus),
    .frame_done(frame_done),
    .frame_count(frame_count),
    .last_line_len(last_line_len),
    .err_line_len(err_line_len),
    .err_line_cnt(err_line_cnt)
  );
  always #5 clk = ~clk;
  px_t q[$];
  int lens[$];
  int checks = 0;
  int passes = 0;
  int done_seen = 0;
  int done_m = 0;
  int mrow = 0;
  int last_len_m = 0;
  logic [15:0] fc_m = '0;
  bit err_len_m = 0;
  bit err_cnt_m = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  function automatic px_t mk(input logic [DW-1:0] d, input int c, input int r);
    px_t p;
    p.d = d;
    p.x = CW'(c);
    p.y = CW'(r);
    p.sof = c == 0 && r == 0;
    p.eol = c == HPIX - 1;
    p.eof = c == HPIX - 1 && r == VPIX - 1;
    return p;
  endfunction
  always @(negedge clk) begin
    px_t act, exp;
    if (frame_done) done_seen++;
    if (bus.px_valid) begin
      act = {bus.px_data, bus.x_pos, bus.y_pos, bus.px_sof, bus.px_eol, bus.px_eof};
      exp = q.size() != 0 ? q.pop_front() : '1;
      chk("px", 64'(act), 64'(exp));
    end
  end
  task automatic check_status(input string tag);
    chk({tag, "_frame_count"}, 64'(frame_count), 64'(fc_m));
    chk({tag, "_err_line_len"}, 64'(err_line_len), 64'(err_len_m));
    chk({tag, "_err_line_cnt"}, 64'(err_line_cnt), 64'(err_cnt_m));
    chk({tag, "_last_line_len"}, 64'(last_line_len), 64'(last_len_m));
    chk({tag, "_frame_done_pulses"}, 64'(done_seen), 64'(done_m));
    chk({tag, "_pixels_outstanding"}, 64'(q.size()), 64'(0));
  endtask
  task automatic drive_line(input int n, input bit push, input bit cut_fv);
    int c;
    c = 0;
    bus.lv = 1'b1;
    if (n == 0) repeat (2) @(negedge clk);
    while (c < n) begin
      if ($urandom_range(0, 3) == 0) bus.pix_en = 1'b0;
      else begin
        bus.pix_en = 1'b1;
        bus.pix_data = DW'($urandom);
        if (push && c < HPIX && mrow < VPIX) q.push_back(mk(bus.pix_data, c, mrow));
        c++;
      end
      @(negedge clk);
    end
    bus.pix_en = 1'b0;
    bus.lv = 1'b0;
    if (cut_fv) bus.fv = 1'b0;
    if (push && n > 0) begin
      mrow++;
      last_len_m = n;
      if (n != HPIX) err_len_m = 1;
    end
    repeat ($urandom_range(2, 4)) @(negedge clk);
  endtask
  task automatic drive_frame(input bit cut, input int drop_line);
    bit cap;
    cap = enable;
    bus.fv = 1'b1;
    mrow = 0;
    repeat (3) @(negedge clk);
    foreach (lens[i]) begin
      drive_line(lens[i], cap, cut && i == lens.size() - 1);
      if (i == drop_line) enable = 1'b0;
    end
    bus.fv = 1'b0;
    repeat (6) @(negedge clk);
    if (cap) begin
      fc_m++;
      done_m++;
      if (mrow != VPIX) err_cnt_m = 1;
    end
    check_status("frame");
  endtask
  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    err_len_m = 0;
    err_cnt_m = 0;
    @(negedge clk);
    chk("clr_err_line_len", 64'(err_line_len), 64'(err_len_m));
    chk("clr_err_line_cnt", 64'(err_line_cnt), 64'(err_cnt_m));
  endtask
  task automatic reset_mid_line();
    bus.fv = 1'b1;
    mrow = 0;
    repeat (3) @(negedge clk);
    drive_line(HPIX, 1, 0);
    bus.lv = 1'b1;
    bus.pix_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.pix_data = DW'($urandom);
      q.push_back(mk(bus.pix_data, c, mrow));
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("rst_px_valid", 64'(bus.px_valid), 64'(0));
    chk("rst_x_pos", 64'(bus.x_pos), 64'(0));
    chk("rst_y_pos", 64'(bus.y_pos), 64'(0));
    chk("rst_frame_count", 64'(frame_count), 64'(0));
    chk("rst_last_line_len", 64'(last_line_len), 64'(0));
    chk("rst_err_line_len", 64'(err_line_len), 64'(0));
    chk("rst_err_line_cnt", 64'(err_line_cnt), 64'(0));
    q.delete();
    fc_m = '0;
    last_len_m = 0;
    err_len_m = 0;
    err_cnt_m = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    bus.pix_en = 1'b0;
    bus.lv = 1'b0;
    repeat (3) @(negedge clk);
    drive_line(HPIX, 0, 0);
    drive_line(HPIX, 0, 0);
    bus.fv = 1'b0;
    repeat (6) @(negedge clk);
    check_status("discard");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bus.fv = 1'b0;
    bus.lv = 1'b0;
    bus.pix_en = 1'b0;
    bus.pix_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_px_valid", 64'(bus.px_valid), 64'(0));
    chk("reset_px_data", 64'(bus.px_data), 64'(0));
    chk("reset_flags", 64'({bus.px_sof, bus.px_eol, bus.px_eof, frame_done}), 64'(0));
    chk("reset_pos", 64'({bus.x_pos, bus.y_pos}), 64'(0));
    chk("reset_frame_count", 64'(frame_count), 64'(0));
    chk("reset_last_line_len", 64'(last_line_len), 64'(0));
    chk("reset_errs", 64'({err_line_len, err_line_cnt}), 64'(0));
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    lens = {HPIX, HPIX, HPIX, HPIX};
    repeat (3) drive_frame(0, -1);
    lens = {HPIX, HPIX, HPIX, HPIX - 1};
    drive_frame(0, -1);
    clear_err();
    lens = {HPIX, HPIX, HPIX, HPIX};
    drive_frame(1, -1);
    lens = {HPIX, HPIX, HPIX, HPIX, HPIX};
    drive_frame(0, -1);
    clear_err();
    lens = {HPIX, HPIX, HPIX, HPIX};
    drive_frame(0, 1);
    drive_frame(0, -1);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    for (int f = 0; f < 8; f++) begin
      int nl;
      nl = $urandom_range(VPIX - 1, VPIX + 1);
      lens.delete();
      for (int l = 0; l < nl; l++) begin
        int r;
        r = $urandom_range(0, 9);
        lens.push_back(r == 0 ? 0 : r < 3 ? $urandom_range(HPIX - 3, HPIX + 3) : HPIX);
      end
      drive_frame(1'($urandom_range(0, 1)), -1);
    end
    lens = {HPIX, HPIX - 2, HPIX, HPIX + 1, HPIX};
    drive_frame(0, -1);
    reset_mid_line();
    lens = {HPIX, HPIX, HPIX, HPIX};
    drive_frame(0, -1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
